// File: rtl/msb_onehot_seq.sv
// Bit-serial MSB finder: scans the captured word one bit per clock, MSB first,
// and returns the isolated most-significant set bit as a one-hot word (or a zero flag).
module msb_onehot_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_onehot,
   output logic             out_zero,
   output logic [1:0]       dbg_state
);

   // Handshake: a word transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] C_TOP = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_data, w_data_nxt;
   logic [WIDTH-1:0] r_probe, w_probe_nxt;
   logic [WIDTH-1:0] r_onehot, w_onehot_nxt;
   logic             r_zero, w_zero_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             w_hit;

   assign w_hit = |(r_data & r_probe);

   always_comb begin
      w_state_nxt     = r_state;
      w_data_nxt      = r_data;
      w_probe_nxt     = r_probe;
      w_onehot_nxt    = r_onehot;
      w_zero_nxt      = r_zero;
      w_out_valid_nxt = r_out_valid;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_data_nxt  = in_data;
               w_probe_nxt = C_TOP;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_hit) begin
               w_onehot_nxt    = r_probe;
               w_zero_nxt      = 1'b0;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end else if (r_probe == C_ONE) begin
               // Bit 0 tested without a hit: the whole word was zero.
               w_onehot_nxt    = '0;
               w_zero_nxt      = 1'b1;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end else begin
               w_probe_nxt = r_probe >> 1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_data      <= '0;
         r_probe     <= '0;
         r_onehot    <= '0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_data      <= w_data_nxt;
         r_probe     <= w_probe_nxt;
         r_onehot    <= w_onehot_nxt;
         r_zero      <= w_zero_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   assign in_ready   = (r_state == S_IDLE) && !rst;
   assign out_valid  = r_out_valid;
   assign out_onehot = r_onehot;
   assign out_zero   = r_zero;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_msb_onehot_seq.sv
// Bench for msb_onehot_seq: directed vectors with literal expectations plus a
// transaction-level model (busy flag, cycle count, expected-result queue) checked every cycle.
module tb_msb_onehot_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_onehot;
   logic         out_zero;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   msb_onehot_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_zero   (out_zero),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // floor(log2(d)) by repeated halving; d must be nonzero
   function automatic int flog2(input int d);
      int v, n;
      v = d;
      n = 0;
      while (v > 1) begin
         v = v / 2;
         n++;
      end
      return n;
   endfunction

   function automatic int latency_of(input int d);
      if (d == 0) return W;
      return W - flog2(d);
   endfunction

   function automatic logic [W:0] result_of(input int d);
      logic [W:0] r;
      r = '0;
      if (d == 0) r[W] = 1'b1;
      else r[flog2(d)] = 1'b1;
      return r;
   endfunction

   // ---------------- model: one transaction in flight ----------------
   logic [W:0] exp_q[$];
   bit m_busy = 1'b0;
   int m_cnt  = 0;
   int m_lat  = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         exp_q.delete();
      end else if (m_busy) begin
         if (m_cnt >= m_lat && out_ready) begin
            m_busy = 1'b0;
            void'(exp_q.pop_front());
         end else begin
            m_cnt++;
         end
      end else if (in_valid) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         m_lat  = latency_of(int'(in_data));
         exp_q.push_back(result_of(int'(in_data)));
      end
   end

   always @(negedge clk) begin
      logic exp_valid;
      exp_valid = m_busy && (m_cnt >= m_lat);
      check("mdl_in_ready", in_ready, !m_busy && !rst);
      check("mdl_out_valid", out_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
         check("mdl_onehot", out_onehot, exp_q[0][W-1:0]);
         check("mdl_zero", out_zero, exp_q[0][W]);
         check("mdl_invariant", (out_zero ? (out_onehot == '0) : ($countones(out_onehot) == 1)), 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] d);
      check("send_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid && cyc < 40);
      if (!out_valid) check("wait_valid_timeout", out_valid, 1);
   endtask

   task automatic do_word(input logic [W-1:0] d, input logic [W-1:0] lit_oh,
                          input logic lit_zero, input int lit_lat);
      int cyc;
      send(d);
      wait_valid(cyc);
      check("lit_latency", cyc, lit_lat);
      check("lit_onehot", out_onehot, lit_oh);
      check("lit_zero", out_zero, lit_zero);
      @(posedge clk); #1;
      check("lit_release", out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int idx;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_onehot", out_onehot, 0);
      check("rst_zero", out_zero, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      do_word(8'h80, 8'h80, 1'b0, 1);
      do_word(8'h05, 8'h04, 1'b0, 6);
      do_word(8'h00, 8'h00, 1'b1, 8);

      // Hold a result with back-pressure while upstream keeps offering words
      out_ready = 1'b0;
      send(8'h10);
      wait_valid(cyc);
      check("hold_latency", cyc, 4);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_onehot", out_onehot, 8'h10);
         check("hold_in_ready", in_ready, 0);
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release_valid", out_valid, 0);
      check("hold_release_in_ready", in_ready, 1);

      // Abort mid-scan with a one-cycle reset
      send(8'h01);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("abort_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_onehot_cleared", out_onehot, 0);
      check("abort_in_ready", in_ready, 1);
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("abort_no_result", out_valid, 0);
      do_word(8'h30, 8'h20, 1'b0, 3);

      // Full sweep with random idle gaps
      for (int d = 0; d < 256; d++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send(W'(d));
         wait_valid(cyc);
         check("sweep_latency", cyc, latency_of(d));
         if (d != 0) begin
            idx = -1;
            for (int i = 0; i < W; i++) if (out_onehot == (W'(1) << i)) idx = i;
            check("sweep_log2", idx, flog2(d));
         end else begin
            check("sweep_zero_flag", out_zero, 1);
         end
         @(posedge clk); #1;
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
